// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator slice.
// Holds the FSM state type, default widths/shift, and the saturation value
// applied to the scaled duty before clamping.
package pwm_pkg;

  localparam int CNT_W_DEFAULT       = 16;
  localparam int DATA_W_DEFAULT      = 16;
  localparam int SCALE_SHIFT_DEFAULT = 8;

  // Largest duty value the scaler can produce before clamping.
  localparam logic [15:0] DUTY_SAT = 16'hFFFF;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_e;

endpackage

// File: rtl/pwm_generator_if.sv
// Sample handshake between the PID controller and the PWM generator.
//   pid_i        controller output sample
//   pid_valid_i  sample valid (driven by the controller)
//   pid_ready_o  PWM block can accept a sample
// master = controller side, slave = PWM generator side.
interface pwm_generator_if
  import pwm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
);

  logic [DATA_W-1:0] pid_i;
  logic              pid_valid_i;
  logic              pid_ready_o;

  modport master (output pid_i, output pid_valid_i, input pid_ready_o);
  modport slave  (input pid_i, input pid_valid_i, output pid_ready_o);

endinterface

// File: rtl/pwm_duty_scaler.sv
// Two-stage duty scaler: multiply the accepted sample by the gain, then
// shift, saturate and clamp it into [duty_min, duty_max].
// Ports:
//   clk_in_i, reset_n_i   clock and synchronous active-low reset
//   pid_if (slave)        sample handshake; owns pid_ready_o
//   scale                 gain, sampled on the accept edge
//   duty_min, duty_max    clamp limits, sampled on the edge after accept
//   pending               clamped duty candidate (valid while pending_wr=1)
//   pending_wr            one-clk strobe: write pending into the shadow reg
module pwm_duty_scaler
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int SCALE_SHIFT = SCALE_SHIFT_DEFAULT
) (
  input  logic              clk_in_i,
  input  logic              reset_n_i,
  pwm_generator_if.slave    pid_if,
  input  logic [DATA_W-1:0] scale,
  input  logic [CNT_W-1:0]  duty_min,
  input  logic [CNT_W-1:0]  duty_max,
  output logic [CNT_W-1:0]  pending,
  output logic              pending_wr
);

  logic [2*DATA_W-1:0] product;
  logic [2*DATA_W-1:0] shifted;
  logic                prod_valid;
  logic [CNT_W-1:0]    sat_value;
  logic [CNT_W-1:0]    clamped;
  logic                accept;

  assign accept = pid_if.pid_valid_i & pid_if.pid_ready_o;

  // Max is applied after min so an inverted limit pair resolves to max.
  always_comb begin
    shifted   = product >> SCALE_SHIFT;
    sat_value = (|shifted[2*DATA_W-1:CNT_W]) ? DUTY_SAT : shifted[CNT_W-1:0];
    clamped   = sat_value;
    if (clamped < duty_min) clamped = duty_min;
    if (clamped > duty_max) clamped = duty_max;
  end

  assign pending    = clamped;
  assign pending_wr = prod_valid;

  // Ready drops for the single clk following each accept.
  always_ff @(posedge clk_in_i) begin
    if (!reset_n_i) begin
      pid_if.pid_ready_o <= 1'b1;
      product            <= '0;
      prod_valid         <= 1'b0;
    end else begin
      pid_if.pid_ready_o <= ~accept;
      prod_valid         <= accept;
      if (accept)
        product <= {{DATA_W{1'b0}}, pid_if.pid_i} * {{DATA_W{1'b0}}, scale};
    end
  end

endmodule

// File: rtl/pwm_generator.sv
// Single-ended PWM generator fed by the PID controller's output samples.
// Accepted samples are scaled/clamped into a pending duty, which only takes
// effect at a period boundary so the output never glitches.
// Ports:
//   clk_in_i, reset_n_i        clock and synchronous active-low reset
//   clk_en_i                   counter tick qualifier
//   enable_i                   1 = run, 0 = force idle
//   period_i                   period in ticks (0 treated as 1)
//   scale_i                    sample gain (256 = 1.0)
//   duty_min_i, duty_max_i     clamp limits
//   pid_if (slave)             sample handshake
//   pwm_o                      registered PWM output
//   period_start_o             one-clk pulse when the counter loads 0
//   duty_o                     currently active duty
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int SCALE_SHIFT = SCALE_SHIFT_DEFAULT
) (
  input  logic              clk_in_i,
  input  logic              reset_n_i,
  input  logic              clk_en_i,
  input  logic              enable_i,
  input  logic [CNT_W-1:0]  period_i,
  input  logic [DATA_W-1:0] scale_i,
  input  logic [CNT_W-1:0]  duty_min_i,
  input  logic [CNT_W-1:0]  duty_max_i,
  pwm_generator_if.slave    pid_if,
  output logic              pwm_o,
  output logic              period_start_o,
  output logic [CNT_W-1:0]  duty_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  pwm_state_e       state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] period_active;
  logic [CNT_W-1:0] duty_active;
  logic [CNT_W-1:0] pending;
  logic             pending_valid;
  logic [CNT_W-1:0] scaled;
  logic             scaled_wr;
  logic [CNT_W-1:0] eff_period;
  logic [CNT_W-1:0] next_duty;
  logic             period_start;

  pwm_duty_scaler #(
    .CNT_W       (CNT_W),
    .DATA_W      (DATA_W),
    .SCALE_SHIFT (SCALE_SHIFT)
  ) u_scaler (
    .clk_in_i   (clk_in_i),
    .reset_n_i  (reset_n_i),
    .pid_if     (pid_if),
    .scale      (scale_i),
    .duty_min   (duty_min_i),
    .duty_max   (duty_max_i),
    .pending    (scaled),
    .pending_wr (scaled_wr)
  );

  // A period starts on the first enabled tick out of IDLE, or when the
  // counter wraps from P-1. The new duty is capped at the new period.
  always_comb begin
    eff_period   = (period_i == '0) ? ONE : period_i;
    next_duty    = duty_active;
    if (pending_valid)
      next_duty = (pending < eff_period) ? pending : eff_period;
    period_start = enable_i & clk_en_i &
                   ((state == IDLE) | (counter == period_active - ONE));
  end

  // pwm_o is computed from the counter value being loaded, so it lines up
  // with the counter without a combinational path to the pin. A scaler
  // write coinciding with a period start lands after the start consumed
  // the old pending value, so it waits for the following period.
  always_ff @(posedge clk_in_i) begin
    if (!reset_n_i) begin
      state          <= IDLE;
      counter        <= '0;
      period_active  <= '0;
      duty_active    <= '0;
      pending        <= '0;
      pending_valid  <= 1'b0;
      pwm_o          <= 1'b0;
      period_start_o <= 1'b0;
    end else begin
      if (scaled_wr) begin
        pending       <= scaled;
        pending_valid <= 1'b1;
      end else if (period_start) begin
        pending_valid <= 1'b0;
      end

      period_start_o <= 1'b0;
      if (!enable_i) begin
        state   <= IDLE;
        counter <= '0;
        pwm_o   <= 1'b0;
      end else if (clk_en_i) begin
        if (period_start) begin
          state          <= RUN;
          counter        <= '0;
          period_active  <= eff_period;
          duty_active    <= next_duty;
          period_start_o <= 1'b1;
          pwm_o          <= (next_duty != '0);
        end else begin
          counter <= counter + ONE;
          pwm_o   <= ((counter + ONE) < duty_active);
        end
      end
    end
  end

  assign duty_o = duty_active;

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// behavioural model of the PWM timing rules.
module tb_pwm_generator;

  logic        clk_in_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        clk_en_i = 1'b0;
  logic        enable_i = 1'b0;
  logic [15:0] period_i = '0;
  logic [15:0] scale_i = 16'd256;
  logic [15:0] duty_min_i = '0;
  logic [15:0] duty_max_i = 16'hFFFF;
  logic        pwm_o;
  logic        period_start_o;
  logic [15:0] duty_o;

  int total = 0;
  int bad = 0;

  pwm_generator_if #(.DATA_W(16)) pid_if ();

  pwm_generator dut (
    .clk_in_i       (clk_in_i),
    .reset_n_i      (reset_n_i),
    .clk_en_i       (clk_en_i),
    .enable_i       (enable_i),
    .period_i       (period_i),
    .scale_i        (scale_i),
    .duty_min_i     (duty_min_i),
    .duty_max_i     (duty_max_i),
    .pid_if         (pid_if),
    .pwm_o          (pwm_o),
    .period_start_o (period_start_o),
    .duty_o         (duty_o)
  );

  always #5 clk_in_i = ~clk_in_i;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: the period is a run of P tick positions; pwm is high
  // while position < duty. Samples become a clamped candidate one edge after
  // acceptance; a period start adopts the candidate present before its edge.
  bit      model_live = 0;
  bit      m_ready, m_run, m_pwm, m_ps, m_pend_valid, pipe_v;
  int      m_pos, m_period, m_duty, m_pend;
  longint  pipe_prod;

  function automatic int scaleClamp(longint prod, int lo, int hi);
    longint v;
    v = prod >> 8;
    if (v > 65535) v = 65535;
    if (v < lo) v = lo;
    if (v > hi) v = hi;
    return int'(v);
  endfunction

  always @(posedge clk_in_i) begin
    bit accept, start, old_pv;
    int old_pend;
    if (!reset_n_i) begin
      m_ready = 1; m_run = 0; m_pwm = 0; m_ps = 0; m_pend_valid = 0;
      pipe_v = 0; m_pos = 0; m_period = 0; m_duty = 0; m_pend = 0;
      model_live = 1;
    end else begin
      accept   = pid_if.pid_valid_i && m_ready;
      old_pend = m_pend;
      old_pv   = m_pend_valid;
      start    = enable_i && clk_en_i && (!m_run || m_pos == m_period - 1);
      m_ps = 0;
      if (!enable_i) begin
        m_run = 0; m_pos = 0; m_pwm = 0;
      end else if (clk_en_i) begin
        if (start) begin
          m_run = 1; m_pos = 0; m_ps = 1;
          m_period = (period_i == 0) ? 1 : int'(period_i);
          if (old_pv) m_duty = (old_pend < m_period) ? old_pend : m_period;
        end else begin
          m_pos++;
        end
        m_pwm = (m_pos < m_duty);
      end
      if (pipe_v) begin
        m_pend = scaleClamp(pipe_prod, int'(duty_min_i), int'(duty_max_i));
        m_pend_valid = 1;
      end else if (start && old_pv) begin
        m_pend_valid = 0;
      end
      pipe_v = accept;
      if (accept) pipe_prod = longint'(pid_if.pid_i) * longint'(scale_i);
      m_ready = !accept;
    end
  end

  // Single per-cycle compare against the model, away from the active edge.
  always @(negedge clk_in_i) begin
    if (model_live) begin
      checkOutput("pwm_o", {31'd0, pwm_o}, {31'd0, m_pwm});
      checkOutput("period_start_o", {31'd0, period_start_o}, {31'd0, m_ps});
      checkOutput("duty_o", {16'd0, duty_o}, m_duty);
      checkOutput("pid_ready_o", {31'd0, pid_if.pid_ready_o}, {31'd0, m_ready});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in_i);
      #1;
    end
  endtask

  // Offer one sample and hold valid until it is taken (bounded).
  task automatic applyStimulus(input logic [15:0] pid);
    bit taken = 0;
    pid_if.pid_i = pid;
    pid_if.pid_valid_i = 1'b1;
    for (int k = 0; k < 8 && !taken; k++) begin
      if (pid_if.pid_ready_o === 1'b1) taken = 1;
      tick(1);
    end
    pid_if.pid_valid_i = 1'b0;
    checkOutput("sample_accepted", {31'd0, taken}, 32'd1);
  endtask

  // Count pwm highs and period starts over n consecutive post-edge samples.
  task automatic countWindow(input int n, output int highs, output int starts);
    highs = 0; starts = 0;
    for (int k = 0; k < n; k++) begin
      if (pwm_o === 1'b1) highs++;
      if (period_start_o === 1'b1) starts++;
      tick(1);
    end
  endtask

  initial begin
    int h, s;
    pid_if.pid_i = 16'd7;
    pid_if.pid_valid_i = 1'b1;
    enable_i = 1'b1;
    clk_en_i = 1'b1;
    tick(3);
    checkOutput("reset_pwm", {31'd0, pwm_o}, 32'd0);
    checkOutput("reset_duty", {16'd0, duty_o}, 32'd0);
    checkOutput("reset_ps", {31'd0, period_start_o}, 32'd0);
    checkOutput("reset_ready", {31'd0, pid_if.pid_ready_o}, 32'd1);
    pid_if.pid_valid_i = 1'b0;
    enable_i = 1'b0;
    reset_n_i = 1'b1;
    tick(2);
    checkOutput("reset_no_accept_duty", {16'd0, duty_o}, 32'd0);

    // Basic: period 10, duty 3
    period_i = 16'd10;
    applyStimulus(16'd3);
    tick(2);
    enable_i = 1'b1;
    tick(1);
    checkOutput("basic_duty", {16'd0, duty_o}, 32'd3);
    countWindow(20, h, s);
    checkOutput("basic_highs", h, 32'd6);
    checkOutput("basic_starts", s, 32'd2);

    // Saturation and clamp to 150 of 200
    enable_i = 1'b0;
    period_i = 16'd200; scale_i = 16'hFFFF; duty_max_i = 16'd150;
    applyStimulus(16'hFFFF);
    tick(2);
    enable_i = 1'b1;
    tick(1);
    checkOutput("sat_duty", {16'd0, duty_o}, 32'd150);
    countWindow(200, h, s);
    checkOutput("sat_highs", h, 32'd150);
    enable_i = 1'b0;
    duty_max_i = 16'd300;
    applyStimulus(16'hFFFF);
    tick(2);
    enable_i = 1'b1;
    tick(1);
    checkOutput("full_duty", {16'd0, duty_o}, 32'd200);
    countWindow(400, h, s);
    checkOutput("full_highs", h, 32'd400);
    checkOutput("full_starts", s, 32'd2);

    // Glitch-free update mid-period
    enable_i = 1'b0;
    period_i = 16'd10; scale_i = 16'd256; duty_max_i = 16'hFFFF;
    applyStimulus(16'd3);
    tick(2);
    enable_i = 1'b1;
    tick(1);
    tick(3);
    applyStimulus(16'd5);
    checkOutput("ready_low_after_accept", {31'd0, pid_if.pid_ready_o}, 32'd0);
    tick(1);
    checkOutput("ready_back", {31'd0, pid_if.pid_ready_o}, 32'd1);
    applyStimulus(16'd8);
    checkOutput("glitch_duty_held", {16'd0, duty_o}, 32'd3);
    tick(4);
    checkOutput("glitch_start", {31'd0, period_start_o}, 32'd1);
    checkOutput("glitch_new_duty", {16'd0, duty_o}, 32'd8);
    countWindow(10, h, s);
    checkOutput("glitch_highs", h, 32'd8);

    // Tick gating: period 4, duty 2, clk_en alternating
    enable_i = 1'b0;
    period_i = 16'd4;
    applyStimulus(16'd2);
    tick(2);
    enable_i = 1'b1;
    h = 0; s = 0;
    for (int k = 0; k < 16; k++) begin
      clk_en_i = ~k[0];
      tick(1);
      if (pwm_o === 1'b1) h++;
      if (period_start_o === 1'b1) s++;
    end
    checkOutput("gate_highs", h, 32'd8);
    checkOutput("gate_starts", s, 32'd2);
    clk_en_i = 1'b1;

    // Disable mid-period, re-enable, then reset mid-period
    enable_i = 1'b0;
    period_i = 16'd10;
    applyStimulus(16'd8);
    tick(2);
    enable_i = 1'b1;
    tick(6);
    checkOutput("pre_disable_pwm", {31'd0, pwm_o}, 32'd1);
    enable_i = 1'b0;
    tick(1);
    checkOutput("disable_pwm", {31'd0, pwm_o}, 32'd0);
    checkOutput("disable_duty_kept", {16'd0, duty_o}, 32'd8);
    enable_i = 1'b1;
    tick(1);
    checkOutput("reenable_ps", {31'd0, period_start_o}, 32'd1);
    checkOutput("reenable_duty", {16'd0, duty_o}, 32'd8);
    tick(3);
    reset_n_i = 1'b0;
    tick(1);
    checkOutput("midreset_pwm", {31'd0, pwm_o}, 32'd0);
    checkOutput("midreset_duty", {16'd0, duty_o}, 32'd0);
    reset_n_i = 1'b1;

    // Randomized phase
    for (int k = 0; k < 3000; k++) begin
      clk_en_i  = ($urandom % 4) != 0;
      enable_i  = ($urandom % 20) != 0;
      reset_n_i = ($urandom % 300) != 0;
      pid_if.pid_valid_i = ($urandom % 3) == 0;
      pid_if.pid_i = 16'($urandom % 4096);
      if ($urandom % 10 == 0) period_i = 16'($urandom % 13);
      if ($urandom % 50 == 0) scale_i = ($urandom % 2) ? 16'd256 : 16'($urandom);
      if ($urandom % 50 == 0) begin
        duty_min_i = 16'($urandom % 6);
        duty_max_i = ($urandom % 2) ? 16'hFFFF : 16'($urandom % 12);
      end
      tick(1);
    end
    pid_if.pid_valid_i = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_generator.md
Name: pwm_generator

Overview:
- Consumes the 16-bit control word produced by pid_controller and turns it into a single-ended PWM output.
- Scales each accepted sample, saturates and clamps it, then applies it as the new duty cycle only on a PWM period boundary, so the output never glitches.
- Sits between the controller's pid_o and the actuator pin.
- Counting is qualified by the same clk_en_i tick used by the controller.

Parameters:
- CNT_W, 16: width of the period counter, period, duty and limit values.
- DATA_W, 16: width of the pid sample and of scale_i.
- SCALE_SHIFT, 8: right shift applied to the product pid_i*scale_i; scale_i=256 means gain 1.0.

Ports:
- clk_in_i  in  1  system clock.
- reset_n_i  in  1  synchronous, active-low reset, sampled on the rising edge of clk_in_i.
- clk_en_i  in  1  counter tick qualifier.
- enable_i  in  1  1 = run PWM; 0 = force idle.
- period_i  in  CNT_W  PWM period in ticks; sampled at period start.
- scale_i  in  DATA_W  gain applied to the sample.
- duty_min_i  in  CNT_W  lower clamp.
- duty_max_i  in  CNT_W  upper clamp.
- pid_i  in  DATA_W  controller output sample.
- pid_valid_i  in  1  sample valid.
- pid_ready_o  out  1  block can accept a sample.
- pwm_o  out  1  PWM output, registered.
- period_start_o  out  1  one-clk pulse when the counter loads 0.
- duty_o  out  CNT_W  currently active duty.

Behaviour:
- Reset: sync, active-low. All of the following reset to 0: pwm_o, period_start_o, duty_o, counter, active period, pending duty, pending_valid. State resets to IDLE. pid_ready_o resets to 1. All inputs are ignored while reset_n_i=0.
- Handshake: a sample is accepted on a clk_in_i edge where pid_valid_i & pid_ready_o. pid_ready_o drops for exactly one cycle after each accept, so the maximum accept rate is one sample per 2 clks. The handshake runs independently of clk_en_i and enable_i.
- Scaler pipeline (latency 2 clks, accept at T):
  - T+1: 32-bit product registered.
  - T+2: product >> SCALE_SHIFT, saturated to 0xFFFF, clamped to [duty_min_i, duty_max_i] (if min > max, max wins). Result is written to pending; pending_valid is set.
  - A newer sample overwrites pending (last wins).
- Period counter: advances only on cycles with clk_en_i=1 in state RUN, counting 0..P-1. Effective period P = max(period_i, 1), captured at each period start.
- States and transitions:
  - IDLE: counter 0, pwm_o 0. Enter RUN on the first enabled tick with enable_i=1. That tick is a period start.
  - RUN: at each period start, load P; if pending_valid, duty_active <= min(pending, P) and clear pending_valid; pulse period_start_o for one clk.
  - RUN -> IDLE: enable_i=0 in any clk. pwm_o=0 and counter=0 in the next clk. Pending and duty_active are retained.
- Output: pwm_o is registered and equals (counter < duty_active) for the current counter value, computed from next-state values so there is no combinational path to the pin.
  - duty_active = 0 gives constant low.
  - duty_active >= P gives constant high across period boundaries with no gap.
- duty_o mirrors duty_active.
- clk_en_i = 0: counter and pwm_o hold; the scaler pipeline keeps running.
- Simultaneous pending write and period start in the same clk: the period start takes the pending value as it was before that edge; the new value waits for the next period.
- period_i changes mid-period: no effect until the next period start.

Decomposition:
- Package pwm_pkg holds:
  - state enum {IDLE, RUN};
  - CNT_W, DATA_W and SCALE_SHIFT defaults;
  - the saturation constant 16'hFFFF.
- Sub-module pwm_duty_scaler contains the 2-stage multiply, shift, saturate and clamp pipeline and owns the ready/valid handshake. Output: pending value plus a one-clk write strobe.
- The top level keeps the FSM, counter, shadow registers and output register.

Test Plan:
- Reset: hold reset_n_i low 3 clks with enable_i=1 and pid_valid_i=1 -> pwm_o=0, duty_o=0, period_start_o=0, pid_ready_o=1, no sample accepted.
- Basic: period_i=10, scale_i=256, pid_i=3, limits 0..0xFFFF, clk_en_i=1 -> duty_o=3 after the next period start; pwm_o high 3 and low 7 clks per period; period_start_o pulses every 10 clks.
- Saturation/clamp: pid_i=0xFFFF, scale_i=0xFFFF, duty_max_i=150, period_i=200 -> scaled value 0xFFFF clamped to 150; pwm_o 150 high / 50 low. With duty_max_i=300 instead -> pwm_o constant high with no low gap at the boundary.
- Glitch-free update: period 10, duty 3; accept pid 5 then pid 8 while counter is 4 -> current period stays 3-high; the next period uses 8; pid_ready_o is low for 1 clk after each accept.
- Tick gating: clk_en_i toggling 1/0, period 4, duty 2 -> pwm_o high 4 clks, low 4 clks; period_start_o pulses every 8 clks.
- Disable/reset mid-period: drop enable_i at counter 5 -> pwm_o=0 next clk. Re-enable -> period_start_o pulses immediately and duty is retained. Assert reset_n_i mid-period -> all outputs 0 and duty_o=0.
